// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and counter sizing.
package rst_seq_pkg;

    localparam logic [2:0] ST_HOLD     = 3'd0;
    localparam logic [2:0] ST_WAIT_RDY = 3'd1;
    localparam logic [2:0] ST_GAP      = 3'd2;
    localparam logic [2:0] ST_RUN      = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

    typedef enum logic [2:0] {
        HOLD     = ST_HOLD,
        WAIT_RDY = ST_WAIT_RDY,
        GAP      = ST_GAP,
        RUN      = ST_RUN,
        DRAIN    = ST_DRAIN
    } seq_state_e;

    // One counter serves both the gap timer and the ready timeout, so size it for the larger.
    function automatic int cnt_width(input int gap_cycles, input int timeout);
        int max_val;
        max_val = (gap_cycles > timeout) ? gap_cycles : timeout;
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rstn_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the second clk edge.
module rstn_sync (
    input  logic clk,
    input  logic rstn_in,
    output logic rstn_sync_out
);

    logic meta;

    always_ff @(posedge clk or negedge rstn_in) begin
        if (!rstn_in) begin
            meta          <= 1'b0;
            rstn_sync_out <= 1'b0;
        end else begin
            meta          <= 1'b1;
            rstn_sync_out <= meta;
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Ordered release of N_STAGES downstream resets with ready handshake, gap timing and
// software-triggered reverse drain.
//   state    | meaning
//   HOLD     | all stages in reset, waiting GAP_CYCLES before releasing stage 0
//   WAIT_RDY | stage cur_stage released, waiting for its ready or TIMEOUT
//   GAP      | waiting GAP_CYCLES before releasing stage cur_stage+1
//   RUN      | all stages released; sw_rst_req starts a drain
//   DRAIN    | re-asserting stages from the top down, GAP_CYCLES apart
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_STAGES   = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                        clk,
    input  logic                        rstn_in,
    input  logic                        sw_rst_req,
    input  logic [N_STAGES-1:0]         stage_rdy,
    output logic [N_STAGES-1:0]         rstn_out,
    output logic [$clog2(N_STAGES)-1:0] cur_stage,
    output logic                        seq_busy,
    output logic                        seq_done,
    output logic                        timeout_err
);

    localparam int              CW         = cnt_width(GAP_CYCLES, TIMEOUT);
    localparam int              SW         = $clog2(N_STAGES);
    localparam logic [CW-1:0]   GAP_TC     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]   TMO_TC     = CW'(TIMEOUT);
    localparam logic [SW-1:0]   LAST_STAGE = SW'(N_STAGES - 1);

    logic          rst_n;
    seq_state_e    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [SW-1:0] nxt_stage;
    logic [SW-1:0] prv_stage;
    logic          gap_tc;
    logic          tmo_tc;
    logic          cur_rdy;

    rstn_sync u_rstn_sync (
        .clk           (clk),
        .rstn_in       (rstn_in),
        .rstn_sync_out (rst_n)
    );

    assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
    assign gap_tc    = (cnt == GAP_TC);
    assign tmo_tc    = (cnt == TMO_TC);
    assign cur_rdy   = stage_rdy[cur_stage];
    assign nxt_stage = cur_stage + 1'b1;
    assign prv_stage = cur_stage - 1'b1;

    assign seq_busy = (state != RUN);
    assign seq_done = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            cnt         <= '0;
            cur_stage   <= '0;
            rstn_out    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    rstn_out <= '0;
                    if (gap_tc) begin
                        state       <= WAIT_RDY;
                        cnt         <= '0;
                        cur_stage   <= '0;
                        rstn_out[0] <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_RDY: begin
                    // A ready arriving on the expiry cycle wins over the timeout.
                    if (cur_rdy || tmo_tc) begin
                        if (!cur_rdy) begin
                            timeout_err <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= (cur_stage == LAST_STAGE) ? RUN : GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                GAP: begin
                    if (gap_tc) begin
                        state               <= WAIT_RDY;
                        cnt                 <= '0;
                        cur_stage           <= nxt_stage;
                        rstn_out[nxt_stage] <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RUN: begin
                    rstn_out <= '1;
                    if (sw_rst_req) begin
                        state                <= DRAIN;
                        cnt                  <= '0;
                        cur_stage            <= LAST_STAGE;
                        rstn_out[LAST_STAGE] <= 1'b0;
                        timeout_err          <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (gap_tc) begin
                        cnt <= '0;
                        if (cur_stage == '0) begin
                            state <= HOLD;
                        end else begin
                            cur_stage           <= prv_stage;
                            rstn_out[prv_stage] <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state    <= HOLD;
                    cnt      <= '0;
                    rstn_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl (N=4, GAP=16, TIMEOUT=255) with hand-computed cycle timing.
module tb_rst_seq_ctrl;

    localparam int N_ST  = 4;
    localparam int GAP_C = 16;
    localparam int TMO_C = 255;

    logic            clk        = 1'b0;
    logic            rstn_in    = 1'b0;
    logic            sw_rst_req = 1'b0;
    logic [N_ST-1:0] stage_rdy  = '0;
    logic [N_ST-1:0] rstn_out;
    logic [1:0]      cur_stage;
    logic            seq_busy;
    logic            seq_done;
    logic            timeout_err;

    int n_vec  = 0;
    int n_err  = 0;
    int edge_n = 0;
    int base   = 0;

    rst_seq_ctrl #(
        .N_STAGES   (N_ST),
        .GAP_CYCLES (GAP_C),
        .TIMEOUT    (TMO_C)
    ) dut (
        .clk         (clk),
        .rstn_in     (rstn_in),
        .sw_rst_req  (sw_rst_req),
        .stage_rdy   (stage_rdy),
        .rstn_out    (rstn_out),
        .cur_stage   (cur_stage),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle c = interval after edge base+c; returns at its falling edge.
    task automatic goto(input int c);
        while (edge_n < base + c) @(negedge clk);
        if (edge_n != base + c) chk($sformatf("sched_c%0d", c), 32'(edge_n - base), 32'(c));
    endtask

    task automatic snap(input string tag, input logic [3:0] ro, input logic [1:0] cs,
                        input logic busy, input logic done, input logic err);
        chk($sformatf("%s.rstn_out", tag),    32'(rstn_out),    32'(ro));
        chk($sformatf("%s.cur_stage", tag),   32'(cur_stage),   32'(cs));
        chk($sformatf("%s.seq_busy", tag),    32'(seq_busy),    32'(busy));
        chk($sformatf("%s.seq_done", tag),    32'(seq_done),    32'(done));
        chk($sformatf("%s.timeout_err", tag), 32'(timeout_err), 32'(err));
    endtask

    task automatic release_rst();
        repeat (3) @(negedge clk);
        rstn_in = 1'b1;
        base    = edge_n + 2;
    endtask

    initial begin
        // Phase A: all ready; sw_rst_req pulses in WAIT_RDY and GAP are ignored
        stage_rdy = 4'b1111;
        repeat (2) @(negedge clk);
        snap("A_in_reset", 4'b0000, 2'd0, 1, 0, 0);
        release_rst();
        goto(0);   snap("A_c0",  4'b0000, 2'd0, 1, 0, 0);
        goto(15);  snap("A_c15", 4'b0000, 2'd0, 1, 0, 0);
        goto(16);  snap("A_c16", 4'b0001, 2'd0, 1, 0, 0);
        sw_rst_req = 1'b1;
        goto(17);  sw_rst_req = 1'b0;
        snap("A_c17", 4'b0001, 2'd0, 1, 0, 0);
        goto(20);  sw_rst_req = 1'b1;
        goto(21);  sw_rst_req = 1'b0;
        goto(32);  snap("A_c32", 4'b0001, 2'd0, 1, 0, 0);
        goto(33);  snap("A_c33", 4'b0011, 2'd1, 1, 0, 0);
        goto(50);  snap("A_c50", 4'b0111, 2'd2, 1, 0, 0);
        goto(66);  snap("A_c66", 4'b0111, 2'd2, 1, 0, 0);
        goto(67);  snap("A_c67", 4'b1111, 2'd3, 1, 0, 0);
        goto(68);  snap("A_c68", 4'b1111, 2'd3, 0, 1, 0);

        // Phase B: drain from RUN, re-release with stage 2 withheld -> timeout
        stage_rdy = 4'b1011;
        goto(80);  snap("B_c80", 4'b1111, 2'd3, 0, 1, 0);
        sw_rst_req = 1'b1;
        goto(81);  sw_rst_req = 1'b0;
        snap("B_c81",  4'b0111, 2'd3, 1, 0, 0);
        goto(96);  snap("B_c96",  4'b0111, 2'd3, 1, 0, 0);
        goto(97);  snap("B_c97",  4'b0011, 2'd2, 1, 0, 0);
        goto(113); snap("B_c113", 4'b0001, 2'd1, 1, 0, 0);
        goto(129); snap("B_c129", 4'b0000, 2'd0, 1, 0, 0);
        goto(160); snap("B_c160", 4'b0000, 2'd0, 1, 0, 0);
        goto(161); snap("B_c161", 4'b0001, 2'd0, 1, 0, 0);
        goto(178); snap("B_c178", 4'b0011, 2'd1, 1, 0, 0);
        goto(195); snap("B_c195", 4'b0111, 2'd2, 1, 0, 0);
        goto(300); snap("B_c300", 4'b0111, 2'd2, 1, 0, 0);
        goto(450); snap("B_c450", 4'b0111, 2'd2, 1, 0, 0);
        goto(451); snap("B_c451", 4'b0111, 2'd2, 1, 0, 1);
        goto(466); snap("B_c466", 4'b0111, 2'd2, 1, 0, 1);
        goto(467); snap("B_c467", 4'b1111, 2'd3, 1, 0, 1);
        goto(468); snap("B_c468", 4'b1111, 2'd3, 0, 1, 1);

        // Phase C: drain clears timeout_err; async reset mid-DRAIN
        goto(480); sw_rst_req = 1'b1;
        goto(481); sw_rst_req = 1'b0;
        snap("C_c481", 4'b0111, 2'd3, 1, 0, 0);
        goto(490);
        #2 rstn_in = 1'b0;
        #1 snap("C_async", 4'b0000, 2'd0, 1, 0, 0);

        // Phase D: stage 3 ready early is ignored until stage 2 ready + gap
        stage_rdy = 4'b1011;
        release_rst();
        goto(0);   snap("D_c0",  4'b0000, 2'd0, 1, 0, 0);
        goto(16);  snap("D_c16", 4'b0001, 2'd0, 1, 0, 0);
        goto(33);  snap("D_c33", 4'b0011, 2'd1, 1, 0, 0);
        goto(59);  snap("D_c59", 4'b0111, 2'd2, 1, 0, 0);
        goto(60);  stage_rdy = 4'b1111;
        goto(76);  snap("D_c76", 4'b0111, 2'd2, 1, 0, 0);
        goto(77);  snap("D_c77", 4'b1111, 2'd3, 1, 0, 0);
        goto(78);  snap("D_c78", 4'b1111, 2'd3, 0, 1, 0);

        // Phase E: ready on the exact timeout-expiry cycle; async reset mid-WAIT_RDY
        goto(90);  sw_rst_req = 1'b1; stage_rdy = 4'b0000;
        goto(91);  sw_rst_req = 1'b0;
        snap("E_c91",  4'b0111, 2'd3, 1, 0, 0);
        goto(139); snap("E_c139", 4'b0000, 2'd0, 1, 0, 0);
        goto(171); snap("E_c171", 4'b0001, 2'd0, 1, 0, 0);
        goto(426); snap("E_c426", 4'b0001, 2'd0, 1, 0, 0);
        stage_rdy = 4'b0001;
        goto(427); stage_rdy = 4'b0000;
        snap("E_c427", 4'b0001, 2'd0, 1, 0, 0);
        goto(442); snap("E_c442", 4'b0001, 2'd0, 1, 0, 0);
        goto(443); snap("E_c443", 4'b0011, 2'd1, 1, 0, 0);
        goto(450);
        #2 rstn_in = 1'b0;
        #1 snap("E_async", 4'b0000, 2'd0, 1, 0, 0);

        // Phase F: restart keeps cycle-0 timing
        stage_rdy = 4'b1111;
        release_rst();
        goto(15);  snap("F_c15", 4'b0000, 2'd0, 1, 0, 0);
        goto(16);  snap("F_c16", 4'b0001, 2'd0, 1, 0, 0);
        goto(33);  snap("F_c33", 4'b0011, 2'd1, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
